// File: rtl/ext_irq_controller_pkg.sv
// Shared definitions for the external interrupt controller:
// register word offsets, bus mode encodings and CTRL layout.
package ext_irq_pkg;

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_PENDING = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_IRQ_SET = 2'd3;

  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  localparam int CTRL_EN_LSB   = 0;
  localparam int CTRL_TYPE_LSB = 2;
  localparam int CTRL_POL_LSB  = 4;

  typedef struct packed {
    logic [1:0] pol;
    logic [1:0] trig;
    logic [1:0] en;
  } ctrl_t;

endpackage

// File: rtl/ext_irq_controller_if.sv
// Address/mode side of the shared data bus; the tristate
// data lines stay a plain port so each side resolves its own driver.
interface ext_irq_controller_if;

  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;

  modport master (
    output data_bus_addr,
    output data_bus_mode
  );

  modport slave (
    input data_bus_addr,
    input data_bus_mode
  );

endinterface

// File: rtl/ext_irq_controller_filter.sv
// One interrupt pin: 2-flop synchroniser, debounce filter
// and edge/level detection on the filtered level.
module irq_channel_filter #(
  parameter int FILTER_CYCLES = 4,
  parameter int FILTER_W      = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic level_i,
  input  logic pol_low_i,
  output logic sync_o,
  output logic filt_o,
  output logic detect_o
);

  localparam logic [FILTER_W-1:0] CNT_LAST =
    FILTER_W'(FILTER_CYCLES - 1);

  logic [1:0]          sync_q, sync_d;
  logic                filt_q, filt_d;
  logic [FILTER_W-1:0] cnt_q, cnt_d;
  logic                differ, accept, active;

  // Detect looks at the next filtered level so a pend lands
  // on the same edge the filtered level changes.
  always_comb begin
    sync_d = {sync_q[0], pin_i};
    differ = sync_q[1] ^ filt_q;
    accept = differ && (cnt_q == CNT_LAST);
    filt_d = accept ? sync_q[1] : filt_q;
    cnt_d  = '0;
    if (differ && !accept) cnt_d = cnt_q + 1'b1;
    active   = filt_d ^ pol_low_i;
    detect_o = active & (level_i | accept);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = sync_q[1];
  assign filt_o = filt_q;

endmodule

// File: rtl/ext_irq_controller.sv
// Memory-mapped conditioner for the two external interrupt
// pins; drives active-low requests into irq_sources[1:0].
module ext_irq_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_2000,
  parameter int          FILTER_CYCLES = 4,
  parameter int          FILTER_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ext_irq_controller_if.slave  bus,
  inout  wire  [31:0]          data_bus_data,
  input  logic [1:0]           int_ext,
  output logic [1:0]           irq_n
);
  import ext_irq_pkg::*;

  ctrl_t       ctrl_q, ctrl_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  irq_n_q, irq_n_d;
  logic [1:0]  sync, filt, detect;
  logic [1:0]  set, clr, word;
  logic        hit, wr_en, rd_en;
  logic [31:0] wdata, rdata;
  logic        unused_bits;

  assign hit   = bus.data_bus_addr[31:4] == BASE_ADDR[31:4];
  assign word  = bus.data_bus_addr[3:2];
  assign wr_en = hit && (bus.data_bus_mode == BUS_WRITE);
  assign rd_en = hit && (bus.data_bus_mode == BUS_READ);
  assign wdata = data_bus_data;

  assign unused_bits =
    ^{bus.data_bus_addr[1:0], wdata[31:6]};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    irq_channel_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .FILTER_W      (FILTER_W)
    ) u_filt (
      .clk_i     (clk),
      .rst_ni    (reset),
      .pin_i     (int_ext[i]),
      .level_i   (ctrl_q.trig[i]),
      .pol_low_i (ctrl_q.pol[i]),
      .sync_o    (sync[i]),
      .filt_o    (filt[i]),
      .detect_o  (detect[i])
    );
  end

  always_comb begin
    ctrl_d = ctrl_q;
    set    = detect;
    clr    = '0;
    if (wr_en) begin
      unique case (word)
        OFF_CTRL: ctrl_d = '{
          pol:  wdata[CTRL_POL_LSB +: 2],
          trig: wdata[CTRL_TYPE_LSB +: 2],
          en:   wdata[CTRL_EN_LSB +: 2]
        };
        OFF_PENDING: clr = wdata[1:0];
        OFF_STATUS:  ;
        OFF_IRQ_SET: set = detect | wdata[1:0];
      endcase
    end
    // a same-cycle set beats the W1C clear
    pend_d  = set | (pend_q & ~clr);
    irq_n_d = ~(pend_q & ctrl_q.en);
  end

  always_comb begin
    rdata = '0;
    unique case (word)
      OFF_CTRL:    rdata[5:0] = ctrl_q;
      OFF_PENDING: rdata[1:0] = pend_q;
      OFF_STATUS:  rdata[3:0] = {sync, filt};
      OFF_IRQ_SET: rdata      = '0;
    endcase
  end

  assign data_bus_data = rd_en ? rdata : 32'bz;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= '0;
      pend_q  <= '0;
      irq_n_q <= 2'b11;
    end else begin
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

endmodule
